// File: rtl/multicycle_control_unit_if.sv
// Control and memory-handshake bundle between the multicycle controller and the MIPS datapath.
interface multicycle_control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_sel;
    logic       illegal_op;
    logic       fault;

    // Controller side: consumes instruction fields and memory handshake, drives control lines.
    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
               alu_sel, illegal_op, fault
    );

    // Datapath side: supplies instruction fields and memory handshake, obeys control lines.
    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
               alu_sel, illegal_op, fault
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: sequences R-type, lw, sw, beq, addi and j over 3-5 cycles,
// with a ready-handshaked memory port and a watchdog on memory wait states.
module multicycle_control_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                             clk,
    input  logic                             reset_n,
    multicycle_control_unit_if.master        bus,
    output logic [3:0]                       state_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b100;

    localparam bit             WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd15
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             mem_wait;

    logic             mem_req_c, mem_we_c, i_or_d_c, ir_write_c, pc_write_c;
    logic             pc_write_cond_c, reg_write_c, reg_dst_c, mem_to_reg_c;
    logic             alu_src_a_c, fault_c;
    logic [1:0]       alu_src_b_c, pc_src_c;
    logic [2:0]       alu_sel_c;
    logic [2:0]       rtype_sel;

    // funct[4:3] play no part in the R-type ALU select.
    logic             unused_funct;
    assign unused_funct = ^bus.funct[4:3];

    // R-type funct to ALU-select mapping inherited from the old combinational decoder.
    assign rtype_sel = {bus.funct[1] | ~bus.funct[5],
                        ~(bus.funct[1] ^ bus.funct[2]),
                        (bus.funct[0] & bus.funct[2]) | (~bus.funct[5] & bus.funct[1])};

    // State, watchdog counter and illegal-opcode pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state sequencing, watchdog trip and counter update.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        cnt_d     = '0;
        mem_wait  = 1'b0;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FETCH;
        endcase

        // A ready on the last tolerated cycle completes normally; only a low ready trips.
        mem_wait = (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !bus.mem_ready;
        if (WD_EN && mem_wait && (cnt_q == CNT_LAST)) begin
            state_d = S_FAULT;
        end
        if (mem_wait && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Control outputs per state; ir_write/pc_write in FETCH follow mem_ready directly.
    always_comb begin
        mem_req_c       = 1'b0;
        mem_we_c        = 1'b0;
        i_or_d_c        = 1'b0;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        reg_write_c     = 1'b0;
        reg_dst_c       = 1'b0;
        mem_to_reg_c    = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        pc_src_c        = 2'b00;
        alu_sel_c       = 3'b000;
        fault_c         = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = 2'b01;
                alu_sel_c   = ALU_ADD;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                alu_sel_c   = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a_c = 1'b1;
                alu_sel_c   = rtype_sel;
            end
            S_WB_R: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_sel_c   = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                i_or_d_c  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_sel_c       = ALU_SUB;
                pc_write_cond_c = 1'b1;
                pc_src_c        = 2'b01;
            end
            S_ADDI_WB: reg_write_c = 1'b1;
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_src_c   = 2'b10;
            end
            S_FAULT:   fault_c = 1'b1;
            default:   ;
        endcase
    end

    // Everything is held low while reset is asserted so an aborted access cannot write.
    assign bus.mem_req       = reset_n & mem_req_c;
    assign bus.mem_we        = reset_n & mem_we_c;
    assign bus.i_or_d        = reset_n & i_or_d_c;
    assign bus.ir_write      = reset_n & ir_write_c;
    assign bus.pc_write      = reset_n & pc_write_c;
    assign bus.pc_write_cond = reset_n & pc_write_cond_c;
    assign bus.reg_write     = reset_n & reg_write_c;
    assign bus.reg_dst       = reset_n & reg_dst_c;
    assign bus.mem_to_reg    = reset_n & mem_to_reg_c;
    assign bus.alu_src_a     = reset_n & alu_src_a_c;
    assign bus.alu_src_b     = {2{reset_n}} & alu_src_b_c;
    assign bus.pc_src        = {2{reset_n}} & pc_src_c;
    assign bus.alu_sel       = {3{reset_n}} & alu_sel_c;
    assign bus.illegal_op    = reset_n & illegal_q;
    assign bus.fault         = reset_n & fault_c;
    assign state_o           = reset_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus randomized instruction streams
// checked cycle by cycle against an instruction-level expected state/control trace.
module tb_multicycle_control_unit;

    localparam int unsigned TIMEOUT = 4;

    localparam int ST_FETCH = 0,  ST_DECODE = 1, ST_EXEC_R = 2,  ST_WB_R = 3;
    localparam int ST_MEM_ADDR = 4, ST_MEM_RD = 5, ST_MEM_WB = 6, ST_MEM_WR = 7;
    localparam int ST_BRANCH = 8, ST_ADDI_EX = 9, ST_ADDI_WB = 10, ST_JUMP = 11, ST_FAULT = 15;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    typedef struct packed {
        logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_sel;
        logic       fault;
    } ctrl_t;

    typedef struct {
        int   st;
        logic rdy;
    } step_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] state_o;
    int         n_checks = 0;
    int         n_fail   = 0;

    multicycle_control_unit_if bus();

    multicycle_control_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t sample_ctrl();
        ctrl_t c;
        c.mem_req       = bus.mem_req;
        c.mem_we        = bus.mem_we;
        c.i_or_d        = bus.i_or_d;
        c.ir_write      = bus.ir_write;
        c.pc_write      = bus.pc_write;
        c.pc_write_cond = bus.pc_write_cond;
        c.reg_write     = bus.reg_write;
        c.reg_dst       = bus.reg_dst;
        c.mem_to_reg    = bus.mem_to_reg;
        c.alu_src_a     = bus.alu_src_a;
        c.alu_src_b     = bus.alu_src_b;
        c.pc_src        = bus.pc_src;
        c.alu_sel       = bus.alu_sel;
        c.fault         = bus.fault;
        return c;
    endfunction

    function automatic logic [2:0] model_funct(logic [5:0] fn);
        logic [2:0] s;
        s[2] = fn[1] || !fn[5];
        s[1] = (fn[1] == fn[2]);
        s[0] = (fn[0] && fn[2]) || (!fn[5] && fn[1]);
        return s;
    endfunction

    // Control word the datapath should see in a given state.
    function automatic ctrl_t exp_ctrl(int st, logic rdy, logic [5:0] fn);
        ctrl_t c = '0;
        case (st)
            ST_FETCH:    begin c.mem_req = 1; c.alu_src_b = 2'b01; c.alu_sel = 3'b010;
                               c.ir_write = rdy; c.pc_write = rdy; end
            ST_DECODE:   begin c.alu_src_b = 2'b11; c.alu_sel = 3'b010; end
            ST_EXEC_R:   begin c.alu_src_a = 1; c.alu_sel = model_funct(fn); end
            ST_WB_R:     begin c.reg_write = 1; c.reg_dst = 1; end
            ST_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_sel = 3'b010; end
            ST_MEM_RD:   begin c.mem_req = 1; c.i_or_d = 1; end
            ST_MEM_WB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
            ST_MEM_WR:   begin c.mem_req = 1; c.mem_we = 1; c.i_or_d = 1; end
            ST_BRANCH:   begin c.alu_src_a = 1; c.alu_sel = 3'b100; c.pc_write_cond = 1;
                               c.pc_src = 2'b01; end
            ST_ADDI_EX:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_sel = 3'b010; end
            ST_ADDI_WB:  c.reg_write = 1;
            ST_JUMP:     begin c.pc_write = 1; c.pc_src = 2'b10; end
            ST_FAULT:    c.fault = 1;
            default:     ;
        endcase
        return c;
    endfunction

    // Holds reset for two edges and releases it just after a rising edge.
    task automatic apply_reset();
        reset_n       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        ctrl_t act;
        reset_n       = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = OP_R;
        bus.funct     = 6'b100000;
        @(negedge clk); #1;
        act = sample_ctrl();
        n_checks++;
        if (act !== ctrl_t'(0)) begin
            n_fail++; $display("FAIL reset_ctrl: got %h expected %h", act, ctrl_t'(0));
        end
        n_checks++;
        if (state_o !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o);
        end
        n_checks++;
        if (bus.illegal_op !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal: got %b expected 0", bus.illegal_op);
        end
        @(posedge clk); #1 reset_n = 1'b1; #1;
        n_checks++;
        if (bus.mem_req !== 1'b1 || state_o !== 4'd0) begin
            n_fail++; $display("FAIL reset_release: got req=%b st=%0d expected req=1 st=0",
                               bus.mem_req, state_o);
        end
    endtask

    task automatic test_add();
        int    exp_st[5];
        ctrl_t act;
        exp_st = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_R, ST_FETCH};
        apply_reset();
        bus.opcode = OP_R;
        bus.funct  = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bus.mem_ready = 1'b1; #1;
            act = sample_ctrl();
            n_checks++;
            if (state_o !== 4'(exp_st[i])) begin
                n_fail++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, state_o, exp_st[i]);
            end
            n_checks++;
            if (act !== exp_ctrl(exp_st[i], 1'b1, bus.funct)) begin
                n_fail++; $display("FAIL add_ctrl[%0d]: got %h expected %h", i, act,
                                   exp_ctrl(exp_st[i], 1'b1, bus.funct));
            end
            if (i == 2) begin
                n_checks++;
                if (act.alu_sel !== 3'b010) begin
                    n_fail++; $display("FAIL add_alu_sel: got %b expected 010", act.alu_sel);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (act.reg_write !== 1'b1 || act.reg_dst !== 1'b1) begin
                    n_fail++; $display("FAIL add_wb: got rw=%b rd=%b expected 1,1",
                                       act.reg_write, act.reg_dst);
                end
            end
        end
    endtask

    task automatic test_lw_wait();
        int    exp_st[9];
        logic  rdy[9];
        ctrl_t act;
        exp_st = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD,
                   ST_MEM_RD, ST_MEM_WB, ST_FETCH};
        rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        bus.opcode = OP_LW;
        bus.funct  = 6'($urandom);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); bus.mem_ready = rdy[i]; #1;
            act = sample_ctrl();
            n_checks++;
            if (state_o !== 4'(exp_st[i])) begin
                n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_o, exp_st[i]);
            end
            n_checks++;
            if (act !== exp_ctrl(exp_st[i], rdy[i], bus.funct)) begin
                n_fail++; $display("FAIL lw_ctrl[%0d]: got %h expected %h", i, act,
                                   exp_ctrl(exp_st[i], rdy[i], bus.funct));
            end
        end
    endtask

    task automatic test_watchdog_fault();
        ctrl_t act;
        apply_reset();
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); bus.mem_ready = (i >= 6); #1;
            act = sample_ctrl();
            n_checks++;
            if (i <= 4) begin
                if (state_o !== 4'd0 || act.fault !== 1'b0 || act.mem_req !== 1'b1) begin
                    n_fail++; $display("FAIL wd_wait[%0d]: got st=%0d fault=%b req=%b expected st=0 fault=0 req=1",
                                       i, state_o, act.fault, act.mem_req);
                end
            end else begin
                if (state_o !== 4'd15 || act !== exp_ctrl(ST_FAULT, 1'b0, 6'd0)) begin
                    n_fail++; $display("FAIL wd_fault[%0d]: got st=%0d ctrl=%h expected st=15 ctrl=%h",
                                       i, state_o, act, exp_ctrl(ST_FAULT, 1'b0, 6'd0));
                end
            end
        end
    endtask

    task automatic test_watchdog_race();
        apply_reset();
        bus.opcode = OP_J;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); bus.mem_ready = (i == 4); #1;
            n_checks++;
            if (state_o !== 4'(i == 5 ? ST_DECODE : ST_FETCH) || bus.fault !== 1'b0) begin
                n_fail++; $display("FAIL wd_race[%0d]: got st=%0d fault=%b expected st=%0d fault=0",
                                   i, state_o, bus.fault, (i == 5 ? ST_DECODE : ST_FETCH));
            end
        end
    endtask

    task automatic test_beq_j();
        int    exp_st[7];
        ctrl_t act;
        exp_st = '{ST_FETCH, ST_DECODE, ST_BRANCH, ST_FETCH, ST_DECODE, ST_JUMP, ST_FETCH};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.opcode    = (i < 3) ? OP_BEQ : OP_J;
            bus.mem_ready = 1'b1;
            #1;
            act = sample_ctrl();
            n_checks++;
            if (state_o !== 4'(exp_st[i])) begin
                n_fail++; $display("FAIL beqj_state[%0d]: got %0d expected %0d", i, state_o, exp_st[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (act.pc_write_cond !== 1'b1 || act.pc_src !== 2'b01 || act.alu_sel !== 3'b100) begin
                    n_fail++; $display("FAIL beq_ctrl: got pwc=%b src=%b alu=%b expected 1,01,100",
                                       act.pc_write_cond, act.pc_src, act.alu_sel);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (act.pc_write !== 1'b1 || act.pc_src !== 2'b10) begin
                    n_fail++; $display("FAIL j_ctrl: got pw=%b src=%b expected 1,10",
                                       act.pc_write, act.pc_src);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int   exp_st[4];
        logic rdy[4];
        logic exp_ill[4];
        exp_st  = '{ST_FETCH, ST_DECODE, ST_FETCH, ST_FETCH};
        rdy     = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_ill = '{1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        bus.opcode = 6'b111111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.mem_ready = rdy[i]; #1;
            n_checks++;
            if (state_o !== 4'(exp_st[i]) || bus.illegal_op !== exp_ill[i]) begin
                n_fail++; $display("FAIL illegal[%0d]: got st=%0d ill=%b expected st=%0d ill=%b",
                                   i, state_o, bus.illegal_op, exp_st[i], exp_ill[i]);
            end
            if (i >= 1) begin
                n_checks++;
                if ({bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.reg_write, bus.mem_we} !== 5'b0) begin
                    n_fail++; $display("FAIL illegal_we[%0d]: got %b expected 00000", i,
                                       {bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.reg_write, bus.mem_we});
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int    exp_st[4];
        logic  rdy[4];
        ctrl_t act;
        exp_st = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR};
        rdy    = '{1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        bus.opcode = OP_SW;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.mem_ready = rdy[i]; #1;
            n_checks++;
            if (state_o !== 4'(exp_st[i])) begin
                n_fail++; $display("FAIL rstwr_state[%0d]: got %0d expected %0d", i, state_o, exp_st[i]);
            end
        end
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            n_fail++; $display("FAIL rstwr_pre: got req=%b we=%b expected 1,1", bus.mem_req, bus.mem_we);
        end
        #2 reset_n = 1'b0; #1;
        act = sample_ctrl();
        n_checks++;
        if (act !== ctrl_t'(0) || state_o !== 4'd0) begin
            n_fail++; $display("FAIL rstwr_drop: got ctrl=%h st=%0d expected 0,0", act, state_o);
        end
        @(posedge clk); #1;
        act = sample_ctrl();
        n_checks++;
        if (act !== ctrl_t'(0) || state_o !== 4'd0) begin
            n_fail++; $display("FAIL rstwr_hold: got ctrl=%h st=%0d expected 0,0", act, state_o);
        end
        reset_n = 1'b1; #1;
        n_checks++;
        if (bus.mem_req !== 1'b1 || state_o !== 4'd0 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL rstwr_release: got req=%b we=%b st=%0d expected 1,0,0",
                               bus.mem_req, bus.mem_we, state_o);
        end
    endtask

    // Random instruction stream, back to back; each instruction expands into its expected states.
    task automatic test_random(int n_instr);
        step_t q[$];
        logic  prev_ill;
        logic  exp_ill;
        ctrl_t act;
        ctrl_t exp;
        prev_ill = 1'b0;
        apply_reset();
        for (int k = 0; k < n_instr; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         kind;
            int         w;
            kind = $urandom_range(0, 6);
            fn   = 6'($urandom);
            case (kind)
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                default: begin
                    op = 6'($urandom);
                    while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) op = 6'($urandom);
                end
            endcase
            q.delete();
            w = $urandom_range(0, TIMEOUT - 1);
            repeat (w) q.push_back(step_t'{ST_FETCH, 1'b0});
            q.push_back(step_t'{ST_FETCH, 1'b1});
            q.push_back(step_t'{ST_DECODE, 1'($urandom)});
            w = $urandom_range(0, TIMEOUT - 1);
            case (kind)
                0: begin
                    q.push_back(step_t'{ST_EXEC_R, 1'($urandom)});
                    q.push_back(step_t'{ST_WB_R, 1'($urandom)});
                end
                1: begin
                    q.push_back(step_t'{ST_MEM_ADDR, 1'($urandom)});
                    repeat (w) q.push_back(step_t'{ST_MEM_RD, 1'b0});
                    q.push_back(step_t'{ST_MEM_RD, 1'b1});
                    q.push_back(step_t'{ST_MEM_WB, 1'($urandom)});
                end
                2: begin
                    q.push_back(step_t'{ST_MEM_ADDR, 1'($urandom)});
                    repeat (w) q.push_back(step_t'{ST_MEM_WR, 1'b0});
                    q.push_back(step_t'{ST_MEM_WR, 1'b1});
                end
                3: q.push_back(step_t'{ST_BRANCH, 1'($urandom)});
                4: begin
                    q.push_back(step_t'{ST_ADDI_EX, 1'($urandom)});
                    q.push_back(step_t'{ST_ADDI_WB, 1'($urandom)});
                end
                5: q.push_back(step_t'{ST_JUMP, 1'($urandom)});
                default: ;
            endcase
            for (int i = 0; i < q.size(); i++) begin
                @(negedge clk);
                bus.opcode    = op;
                bus.funct     = fn;
                bus.mem_ready = q[i].rdy;
                #1;
                act     = sample_ctrl();
                exp     = exp_ctrl(q[i].st, q[i].rdy, fn);
                exp_ill = (i == 0) ? prev_ill : 1'b0;
                n_checks++;
                if (state_o !== 4'(q[i].st)) begin
                    n_fail++; $display("FAIL rand_state[%0d.%0d] op=%b: got %0d expected %0d",
                                       k, i, op, state_o, q[i].st);
                end
                n_checks++;
                if (act !== exp) begin
                    n_fail++; $display("FAIL rand_ctrl[%0d.%0d] op=%b fn=%b: got %h expected %h",
                                       k, i, op, fn, act, exp);
                end
                n_checks++;
                if (bus.illegal_op !== exp_ill) begin
                    n_fail++; $display("FAIL rand_illegal[%0d.%0d]: got %b expected %b",
                                       k, i, bus.illegal_op, exp_ill);
                end
            end
            prev_ill = (kind == 6);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_watchdog_fault();
        test_watchdog_race();
        test_beq_j();
        test_illegal();
        test_reset_mid_write();
        test_random(80);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
